// File: rtl/vram_line_prefetch_buffer.sv
// Ping-pong scanline buffer: fills the back bank from VRAM while the front bank
// feeds the pixel path, releasing the bus to host ISA cycles between words.
//
// state    | meaning
// IDLE     | no fill requested since reset
// ARB      | waiting for isa_req to drop before taking the bus
// RD_ADDR  | address and strobes driven for one word
// RD_LATCH | word captured into the back bank, pointers advance
// YIELD    | bus released after a burst or on host request
// FULL     | back bank holds a complete line, waiting for line_start
module vram_line_prefetch_buffer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int LINE_WORDS = 640,
  parameter int BURST      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              active,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              isa_req,
  input  logic [DATA_W-1:0] vram_data_in,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_ce_n,
  output logic              vram_rd_n,
  output logic              fetch_active,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  output logic              fill_done
);
  localparam int CNT_W  = $clog2(LINE_WORDS + 1);
  localparam int BST_W  = $clog2(BURST + 1);
  localparam int MEM_D  = 2 * LINE_WORDS;
  localparam int MEM_AW = $clog2(MEM_D);

  typedef enum logic [2:0] {IDLE, ARB, RD_ADDR, RD_LATCH, YIELD, FULL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, line_addr;
  logic [CNT_W-1:0]  fill_cnt, rd_ptr;
  logic [BST_W-1:0]  burst_cnt;
  logic              front, fill_bank, line_bad;
  logic              latch_word, last_word, burst_last;
  logic [MEM_AW-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0] mem [MEM_D];

  assign latch_word = (state == RD_LATCH) && !frame_start && !line_start;
  assign last_word  = (fill_cnt == CNT_W'(LINE_WORDS - 1));
  assign burst_last = (burst_cnt == BST_W'(BURST - 1));
  assign wr_idx     = (fill_bank ? MEM_AW'(LINE_WORDS) : '0) + MEM_AW'(fill_cnt);
  assign rd_idx     = (front ? MEM_AW'(LINE_WORDS) : '0) + MEM_AW'(rd_ptr);

  // Strobes decode straight from the state register so reset releases the bus at once.
  assign fetch_active = (state == RD_ADDR) || (state == RD_LATCH);
  assign vram_ce_n    = !fetch_active;
  assign vram_rd_n    = !fetch_active;
  assign vram_addr    = ptr;

  always_comb begin
    state_nxt = state;
    if (frame_start || line_start) begin
      state_nxt = ARB;
    end else begin
      case (state)
        ARB:      if (!isa_req) state_nxt = RD_ADDR;
        RD_ADDR:  state_nxt = RD_LATCH;
        RD_LATCH: begin
          if (last_word)                  state_nxt = FULL;
          else if (burst_last || isa_req) state_nxt = YIELD;
          else                            state_nxt = RD_ADDR;
        end
        YIELD:    state_nxt = ARB;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      line_addr <= '0;
      fill_cnt  <= '0;
      burst_cnt <= '0;
      front     <= 1'b0;
      fill_bank <= 1'b0;
      line_bad  <= 1'b0;
      fill_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        ptr       <= base_addr;
        line_addr <= base_addr;
        front     <= 1'b0;
        fill_bank <= 1'b0;
        fill_cnt  <= '0;
        burst_cnt <= '0;
        fill_done <= 1'b0;
        line_bad  <= 1'b0;
      end else if (line_start) begin
        // Whether or not the fill finished, the next fetch starts at the following line.
        front     <= fill_bank;
        fill_bank <= !fill_bank;
        line_addr <= line_addr + ADDR_W'(LINE_WORDS);
        ptr       <= line_addr + ADDR_W'(LINE_WORDS);
        fill_cnt  <= '0;
        burst_cnt <= '0;
        fill_done <= 1'b0;
        line_bad  <= !fill_done;
        if (!fill_done) underrun <= 1'b1;
      end else if (state == RD_LATCH) begin
        ptr       <= ptr + ADDR_W'(1);
        fill_cnt  <= fill_cnt + CNT_W'(1);
        burst_cnt <= burst_cnt + BST_W'(1);
        if (last_word) fill_done <= 1'b1;
      end else if (state == YIELD) begin
        burst_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_word) mem[wr_idx] <= vram_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else if (frame_start || line_start) begin
      rd_ptr    <= '0;
      pix_valid <= 1'b0;
    end else if (!active) begin
      pix_valid <= 1'b0;
    end else if (pix_ce) begin
      if (rd_ptr == CNT_W'(LINE_WORDS)) begin
        pix_valid <= 1'b0;
        pix_data  <= '0;
      end else begin
        pix_data  <= mem[rd_idx];
        pix_valid <= !line_bad;
        rd_ptr    <= rd_ptr + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_line_prefetch_buffer.sv
// Bench for vram_line_prefetch_buffer: directed line scenarios from a table,
// hand-written corner sequences and random traffic checked by a line-level model.
module tb_vram_line_prefetch_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
  localparam int LW     = 8;
  localparam int BURST  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_ce = 1'b0;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              active = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              isa_req = 1'b0;
  logic [DATA_W-1:0] vram_data_in;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ce_n, vram_rd_n, fetch_active;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid, underrun, fill_done;

  int n_pass = 0;
  int n_total = 0;

  vram_line_prefetch_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LW), .BURST(BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .frame_start(frame_start),
    .line_start(line_start), .active(active), .base_addr(base_addr),
    .isa_req(isa_req), .vram_data_in(vram_data_in), .vram_addr(vram_addr),
    .vram_ce_n(vram_ce_n), .vram_rd_n(vram_rd_n), .fetch_active(fetch_active),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  // VRAM contents are a fixed function of address, so any line can be predicted.
  function automatic logic [15:0] vram_word(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ 16'hA455;
  endfunction
  assign vram_data_in = vram_word(vram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Line-level model: words fetched for the line in progress, and the line on display.
  logic [19:0] m_line, m_addr, show_addr;
  int          m_count, pix_idx, low_run;
  bit          m_under, show_ok, exp_valid, dchk, prev_ce_n, prev_isa;
  logic [15:0] exp_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_line = '0; m_addr = '0; show_addr = '0; m_count = 0; pix_idx = 0;
      m_under = 0; show_ok = 0; exp_valid = 0; exp_data = '0; dchk = 1;
      low_run = 0; prev_ce_n = 1; prev_isa = 0;
    end else begin
      chk("fill_done", 32'(fill_done), 32'(m_count == LW));
      chk("underrun", 32'(underrun), 32'(m_under));
      chk("pix_valid", 32'(pix_valid), 32'(exp_valid));
      if (dchk) chk("pix_data", 32'(pix_data), 32'(exp_data));
      if (!vram_ce_n) begin
        low_run++;
        if (prev_ce_n) chk("bus_taken_during_isa", 32'(prev_isa), 32'(0));
        chk("vram_addr", 32'(vram_addr), 32'(m_addr));
        chk("rd_n_low", 32'(vram_rd_n), 32'(0));
        chk("fetch_active_hi", 32'(fetch_active), 32'(1));
        chk("no_overfetch", 32'(m_count < LW), 32'(1));
        chk("burst_len", 32'(low_run <= 2 * BURST), 32'(1));
        if ((low_run % 2 == 0) && !frame_start && !line_start) begin
          m_count++;
          m_addr = m_addr + 20'(1);
        end
      end else begin
        low_run = 0;
        chk("rd_n_high", 32'(vram_rd_n), 32'(1));
        chk("fetch_active_lo", 32'(fetch_active), 32'(0));
      end
      prev_ce_n = vram_ce_n;
      prev_isa  = isa_req;
      if (frame_start) begin
        m_line = base_addr; m_addr = base_addr; m_count = 0; pix_idx = 0; show_ok = 0;
      end else if (line_start) begin
        show_ok   = (m_count == LW);
        show_addr = m_line;
        if (m_count != LW) m_under = 1;
        m_line  = m_line + 20'(LW);
        m_addr  = m_line;
        m_count = 0;
        pix_idx = 0;
      end
      if (!active) begin
        exp_valid = 0;
      end else if (pix_ce && !frame_start && !line_start) begin
        if (pix_idx == LW) begin
          exp_valid = 0; exp_data = '0; dchk = 1;
        end else begin
          exp_valid = show_ok;
          exp_data  = vram_word(show_addr + 20'(pix_idx));
          dchk      = show_ok;
          pix_idx++;
        end
      end
    end
  end

  typedef struct {
    logic [19:0] base;
    int          ls_delay;
    int          isa_at;
    int          isa_len;
    logic        exp_done;
    logic        exp_under;
    logic [19:0] exp_next;
  } vec_t;
  vec_t vecs[6];

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 0; frame_start = 0; line_start = 0; active = 0; pix_ce = 0; isa_req = 0;
    #1;
    chk("rst_ce_n", 32'(vram_ce_n), 32'(1));
    chk("rst_rd_n", 32'(vram_rd_n), 32'(1));
    chk("rst_addr", 32'(vram_addr), 32'(0));
    chk("rst_fetch_active", 32'(fetch_active), 32'(0));
    chk("rst_pix_data", 32'(pix_data), 32'(0));
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    chk("rst_fill_done", 32'(fill_done), 32'(0));
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic start_frame(input logic [19:0] base);
    base_addr = base; frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
  endtask

  task automatic isa_step();
    if (isa_req) begin
      if ($urandom_range(0, 3) == 0) isa_req = 0;
    end else if ($urandom_range(0, 11) == 0) begin
      isa_req = 1;
    end
  endtask

  initial begin
    int t;
    vecs[0] = '{20'h00100, 40, -1, 0, 1'b1, 1'b0, 20'h00108};
    vecs[1] = '{20'h00100, 8, -1, 0, 1'b0, 1'b1, 20'h00108};
    vecs[2] = '{20'hFFFFC, 40, -1, 0, 1'b1, 1'b0, 20'h00004};
    vecs[3] = '{20'h00200, 40, 3, 30, 1'b0, 1'b1, 20'h00208};
    vecs[4] = '{20'h00300, 60, 5, 10, 1'b1, 1'b0, 20'h00308};
    vecs[5] = '{20'hFFFF8, 40, -1, 0, 1'b1, 1'b0, 20'h00000};

    for (int i = 0; i < 6; i++) begin
      reset_dut();
      start_frame(vecs[i].base);
      for (int c = 1; c < vecs[i].ls_delay; c++) begin
        isa_req = (vecs[i].isa_at >= 0) && (c >= vecs[i].isa_at) &&
                  (c < vecs[i].isa_at + vecs[i].isa_len);
        @(posedge clk); #1;
      end
      isa_req = 0;
      chk($sformatf("vec%0d_fill_done", i), 32'(fill_done), 32'(vecs[i].exp_done));
      line_start = 1;
      @(posedge clk); #1 line_start = 0;
      chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_under));
      t = 0;
      while (vram_ce_n && t < 40) begin @(posedge clk); #1; t++; end
      chk($sformatf("vec%0d_fetch_seen", i), 32'(!vram_ce_n), 32'(1));
      if (!vram_ce_n)
        chk($sformatf("vec%0d_next_addr", i), 32'(vram_addr), 32'(vecs[i].exp_next));
    end

    // Host cycle raised while word 2 is on the bus.
    reset_dut();
    start_frame(20'h00100);
    t = 0;
    while (!(!vram_ce_n && vram_addr == 20'h00102) && t < 60) begin @(posedge clk); #1; t++; end
    chk("isa_word2_reached", 32'(!vram_ce_n && vram_addr == 20'h00102), 32'(1));
    isa_req = 1;
    @(posedge clk); #1;
    chk("isa_word_in_flight", 32'(vram_ce_n), 32'(0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("isa_bus_released", 32'(vram_ce_n), 32'(1));
    end
    isa_req = 0;
    t = 0;
    while (vram_ce_n && t < 6) begin @(posedge clk); #1; t++; end
    chk("isa_resume_addr", 32'(vram_addr), 32'(20'h00103));

    // Show the completed line with pix_ce every second cycle.
    t = 0;
    while (!fill_done && t < 60) begin @(posedge clk); #1; t++; end
    chk("line0_filled", 32'(fill_done), 32'(1));
    line_start = 1;
    @(posedge clk); #1 line_start = 0;
    active = 1;
    for (int k = 0; k < 20; k++) begin
      pix_ce = (k % 2 == 0);
      @(posedge clk); #1;
    end
    pix_ce = 0;
    chk("line_end_invalid", 32'(pix_valid), 32'(0));
    chk("line_end_zero", 32'(pix_data), 32'(0));
    active = 0;

    // Reset during the latch cycle must release the bus without a clock edge.
    reset_dut();
    start_frame(20'h00040);
    t = 0;
    while (vram_ce_n && t < 10) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    chk("latch_cycle_bus_low", 32'(vram_ce_n), 32'(0));
    rst_n = 0;
    #1;
    chk("async_rst_ce_n", 32'(vram_ce_n), 32'(1));
    chk("async_rst_rd_n", 32'(vram_rd_n), 32'(1));
    chk("async_rst_fetch", 32'(fetch_active), 32'(0));
    chk("async_rst_addr", 32'(vram_addr), 32'(0));
    @(posedge clk); #1 rst_n = 1;

    // Random frames with ISA traffic; the monitor model checks every cycle.
    reset_dut();
    for (int f = 0; f < 4; f++) begin
      start_frame((f == 1) ? 20'hFFFE8 : 20'($urandom));
      repeat ($urandom_range(20, 30)) begin isa_step(); @(posedge clk); #1; end
      for (int l = 0; l < 10; l++) begin
        line_start = 1; isa_step();
        @(posedge clk); #1 line_start = 0;
        active = 1;
        repeat (20) begin
          pix_ce = 1'($urandom_range(0, 1));
          isa_step();
          @(posedge clk); #1;
        end
        active = 0; pix_ce = 0;
        repeat ($urandom_range(0, 12)) begin isa_step(); @(posedge clk); #1; end
      end
    end
    isa_req = 0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_line_prefetch_buffer.md
Name: vram_line_prefetch_buffer

Overview:
- Parametrised ping-pong scanline buffer between the VRAM/SRAM bus and the pixel output path.
- While line N is shown from the front bank, fetches line N+1 from VRAM into the back bank, yielding the bus to pending ISA host cycles.
- Generalises the managed VRAM data buffer with bank swap:
  - configurable pixel width, line length and fetch burst;
  - pixel-rate enable on a single clock;
  - mid-burst ISA yield;
  - sticky underrun reporting.

Parameters:
- DATA_W, 16: VRAM word and pixel width in bits.
- ADDR_W, 20: VRAM address width.
- LINE_WORDS, 640: words per scanline; depth of each bank.
- BURST, 8: maximum words fetched before re-checking isa_req.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_ce  in  1  pixel-rate clock enable.
- frame_start  in  1  one-cycle pulse at start of vblank.
- line_start  in  1  one-cycle pulse at each HSYNC edge.
- active  in  1  visible-region flag.
- base_addr  in  ADDR_W  VRAM address of line 0; sampled on frame_start.
- isa_req  in  1  host ISA cycle pending or in progress; fetch must release the bus.
- vram_data_in  in  DATA_W  VRAM read data.
- vram_addr  out  ADDR_W  fetch address.
- vram_ce_n  out  1  VRAM chip enable, active low.
- vram_rd_n  out  1  VRAM read strobe, active low.
- fetch_active  out  1  high while this block owns the VRAM bus.
- pix_data  out  DATA_W  current pixel word.
- pix_valid  out  1  pix_data is a fetched word.
- underrun  out  1  sticky: a line swap happened before its fill completed.
- fill_done  out  1  back bank completely filled.

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-fetch):
- vram_ce_n=1, vram_rd_n=1, vram_addr=0, fetch_active=0.
- pix_data=0, pix_valid=0, underrun=0, fill_done=0.
- front bank=0, state IDLE, all counters 0.

FSM states: IDLE, ARB, RD_ADDR, RD_LATCH, YIELD, FULL.

IDLE:
- Waits for frame_start or line_start (see below).

ARB:
- If isa_req=1, stay in ARB; fetch_active=0 and strobes high.
- Otherwise go to RD_ADDR and assert fetch_active.

RD_ADDR (1 cycle):
- Drives vram_addr = fetch pointer, vram_ce_n=0, vram_rd_n=0.

RD_LATCH (1 cycle):
- Strobes stay low.
- vram_data_in is written into the back bank at word index fill_cnt.
- Fetch pointer and fill_cnt increment.
- Each word therefore costs 2 clk cycles.

Next state after RD_LATCH:
- fill_cnt reaches LINE_WORDS → FULL; fill_done=1; strobes high; fetch_active=0.
- burst counter reaches BURST, or isa_req=1 → YIELD.
  - isa_req is never honoured between RD_ADDR and RD_LATCH; the word in flight always completes.
- Otherwise → RD_ADDR.

YIELD:
- Strobes high and fetch_active=0 on entry; burst counter cleared.
- Go to ARB on the next cycle.

Address arithmetic:
- Fetch pointer is ADDR_W bits and wraps modulo 2^ADDR_W.
- It continues linearly across lines; line N+1 starts at base_addr + (N+1)*LINE_WORDS.

frame_start:
- Load fetch pointer = base_addr; front bank=0.
- Clear fill_cnt, fill_done and the read pointer.
- Fill bank 0 with line 0 (ARB).

line_start:
- If fill_done=1: toggle front bank, clear the read pointer, clear fill_done, start filling the new back bank (ARB).
- If fill_done=0: set underrun, abort the current word without latching it, and toggle banks anyway.
  - The new front bank shows stale data, and pix_valid=0 for that whole line.
  - The fetch pointer advances to the start of the following line; fill restarts into the new back bank.
- The first line_start after frame_start makes bank 0 the front bank and begins fetching line 1.

Simultaneous events:
- frame_start and line_start in the same cycle: frame_start wins.
- frame_start and isa_req: frame_start resets pointers; ARB then waits on isa_req.

Pixel read side:
- On pix_ce & active, pix_data = front[rd_ptr] is registered one clk later, and rd_ptr increments.
- When rd_ptr = LINE_WORDS: rd_ptr holds, pix_valid=0, pix_data=0.
- When active=0: pix_valid=0 and pix_data holds.

underrun:
- Cleared only by reset.

Test Plan:
1. LINE_WORDS=8, BURST=4, isa_req=0, base_addr=0x00100; frame_start → vram_addr runs 0x00100..0x00107, 2 cycles/word, fill_done=1 after 16 cycles, fetch_active falls the same cycle.
2. isa_req raised during RD_ADDR of word 2 → word 2 is still latched, next RD_ADDR is delayed until isa_req=0, and vram_ce_n stays high throughout isa_req.
3. Full line, then line_start with data words 0xA455,0xFFFF,… → with pix_ce every 2nd cycle and active=1, pix_data emits the 8 words in order one clk after each pix_ce, then pix_valid=0; the back-bank fetch starts at 0x00108.
4. line_start issued when fill_cnt=3 → underrun=1 and stays 1 after further lines, pix_valid=0 for that line, and the next fetch begins at line start +8.
5. base_addr=0xFFFFC, LINE_WORDS=8 → addresses wrap 0xFFFFF→0x00000.
6. rst_n pulled low during RD_LATCH → vram_ce_n/vram_rd_n go high immediately without waiting for clk, and all outputs take their reset values.
